// File: rtl/operand_collector.sv
// operand_collector: stages NUM_OPS operands from one register-bank read
// port into slots, then pushes the complete set as a bundle into a
// DEPTH-entry queue that the ALU drains with valid/ready.

// One operand slot: value plus valid flag. A load always wins over a clear
// so an operand written in the issue cycle belongs to the next bundle.
module operand_slot #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] value,
  output logic             valid
);

  // Capture on load; drop the flag on clear unless reloaded this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
      valid <= 1'b0;
    end else if (load) begin
      value <= data;
      valid <= 1'b1;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

module operand_collector #(
  parameter int WIDTH   = 16,
  parameter int NUM_OPS = 2,
  parameter int DEPTH   = 2,
  parameter int STICKY  = 0,
  parameter int SELW    = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1,
  parameter int CW      = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         reg_data,
  input  logic                     reg_load,
  input  logic [SELW-1:0]          op_sel,
  input  logic                     issue,
  input  logic                     alu_ready,
  output logic                     alu_valid,
  output logic [WIDTH*NUM_OPS-1:0] alu_ops,
  output logic                     slots_full,
  output logic [CW-1:0]            queue_count,
  output logic                     issue_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = WIDTH * NUM_OPS;

  logic [NUM_OPS-1:0]            slot_load;
  logic [NUM_OPS-1:0]            slot_valid;
  logic [NUM_OPS-1:0][WIDTH-1:0] slot_value;

  logic [DEPTH-1:0][BW-1:0] mem;
  logic [PW-1:0]            head, tail;
  logic [CW-1:0]            count;

  logic sel_ok, pop, accept, clear;

  // Out-of-range selects (possible when NUM_OPS is not a power of two)
  // must leave every slot untouched.
  assign sel_ok     = int'(op_sel) < NUM_OPS;
  assign slots_full = &slot_valid;
  assign alu_valid  = (count != '0);
  assign pop        = alu_valid && alu_ready;
  // A pop in the same cycle frees an entry, so a full queue still accepts.
  assign accept     = issue && slots_full && ((count < CW'(DEPTH)) || pop);
  assign clear      = accept && (STICKY == 0);

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_slot
    assign slot_load[i] = reg_load && sel_ok && (op_sel == SELW'(i));

    operand_slot #(.WIDTH(WIDTH)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (slot_load[i]),
      .clear (clear),
      .data  (reg_data),
      .value (slot_value[i]),
      .valid (slot_valid[i])
    );
  end

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Bundle storage: pre-edge slot values land at the tail on accept.
  // Contents need no reset; the count gates everything visible.
  always_ff @(posedge clk) begin
    if (accept) mem[tail] <= slot_value;
  end

  // Queue pointers and occupancy; reset discards everything queued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop)    head <= ptr_next(head);
      if (accept) tail <= ptr_next(tail);
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // One-cycle error pulse for each rejected issue request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) issue_err <= 1'b0;
    else     issue_err <= issue && !accept;
  end

  assign alu_ops     = alu_valid ? mem[head] : '0;
  assign queue_count = count;

endmodule

// File: tb/tb_operand_collector.sv
// Bench: three collector configurations driven in lockstep against a
// queue-based reference model; directed scenarios followed by random traffic.
module tb_operand_collector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance 0: N2 D2 non-sticky, 1: N2 D2 sticky, 2: N3 D3 non-sticky
  logic [2:0]  ld, iss, rdy;
  logic [1:0]  sel [3];
  logic [15:0] dat [3];
  wire  [2:0]  av, sf, ie;
  wire  [31:0] ops_a, ops_b;
  wire  [47:0] ops_c;
  wire  [1:0]  qc_a, qc_b, qc_c;

  operand_collector #(.WIDTH(16), .NUM_OPS(2), .DEPTH(2), .STICKY(0)) u_a (
    .clk(clk), .rst(rst), .reg_data(dat[0]), .reg_load(ld[0]), .op_sel(sel[0][0]),
    .issue(iss[0]), .alu_ready(rdy[0]), .alu_valid(av[0]), .alu_ops(ops_a),
    .slots_full(sf[0]), .queue_count(qc_a), .issue_err(ie[0]));

  operand_collector #(.WIDTH(16), .NUM_OPS(2), .DEPTH(2), .STICKY(1)) u_b (
    .clk(clk), .rst(rst), .reg_data(dat[1]), .reg_load(ld[1]), .op_sel(sel[1][0]),
    .issue(iss[1]), .alu_ready(rdy[1]), .alu_valid(av[1]), .alu_ops(ops_b),
    .slots_full(sf[1]), .queue_count(qc_b), .issue_err(ie[1]));

  operand_collector #(.WIDTH(16), .NUM_OPS(3), .DEPTH(3), .STICKY(0)) u_c (
    .clk(clk), .rst(rst), .reg_data(dat[2]), .reg_load(ld[2]), .op_sel(sel[2]),
    .issue(iss[2]), .alu_ready(rdy[2]), .alu_valid(av[2]), .alu_ops(ops_c),
    .slots_full(sf[2]), .queue_count(qc_c), .issue_err(ie[2]));

  int NP [3] = '{2, 2, 3};
  int DP [3] = '{2, 2, 3};
  int SP [3] = '{0, 1, 0};

  // reference model state
  logic [15:0] mv   [3][3];
  bit          mf   [3][3];
  logic [47:0] mq   [3][$];
  bit          merr [3];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] got_ops(input int k);
    case (k)
      0:       return {16'h0, ops_a};
      1:       return {16'h0, ops_b};
      default: return ops_c;
    endcase
  endfunction

  function automatic logic [1:0] got_qc(input int k);
    case (k)
      0:       return qc_a;
      1:       return qc_b;
      default: return qc_c;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mq[k].delete();
      merr[k] = 0;
      for (int i = 0; i < 3; i++) begin
        mv[k][i] = '0;
        mf[k][i] = 0;
      end
    end
  endtask

  // Advance the model by one clock using the inputs presented right now
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      bit full, pop, acc;
      logic [47:0] b;
      full = 1;
      b = '0;
      for (int i = 0; i < NP[k]; i++) begin
        full = full & mf[k][i];
        b[i*16 +: 16] = mv[k][i];
      end
      pop = (mq[k].size() > 0) && rdy[k];
      acc = iss[k] && full && ((mq[k].size() < DP[k]) || pop);
      merr[k] = iss[k] && !acc;
      if (pop) void'(mq[k].pop_front());
      if (acc) mq[k].push_back(b);
      if (acc && SP[k] == 0)
        for (int i = 0; i < 3; i++) mf[k][i] = 0;
      if (ld[k] && int'(sel[k]) < NP[k]) begin
        mv[k][sel[k]] = dat[k];
        mf[k][sel[k]] = 1;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      bit full;
      logic [47:0] e;
      full = 1;
      for (int i = 0; i < NP[k]; i++) full = full & mf[k][i];
      e = (mq[k].size() > 0) ? mq[k][0] : 48'h0;
      chk($sformatf("valid[%0d]", k), av[k], mq[k].size() > 0);
      chk($sformatf("ops[%0d]", k), got_ops(k), e);
      chk($sformatf("count[%0d]", k), got_qc(k), mq[k].size());
      chk($sformatf("full[%0d]", k), sf[k], full);
      chk($sformatf("err[%0d]", k), ie[k], merr[k]);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    ld  = '0;
    iss = '0;
  endtask

  task automatic load(input int k, input logic [1:0] s, input logic [15:0] d);
    ld[k]  = 1'b1;
    sel[k] = s;
    dat[k] = d;
    tick();
  endtask

  initial begin
    ld = '0; iss = '0; rdy = '0;
    for (int k = 0; k < 3; k++) begin
      sel[k] = '0;
      dat[k] = '0;
    end
    model_reset();
    #12;
    check_all();
    chk("rst_valid", av, 3'b000);
    @(negedge clk);
    rst = 1'b0;

    // basic load, issue, drain on the non-sticky pair
    load(0, 2'd0, 16'h1234);
    load(0, 2'd1, 16'hABCD);
    chk("tp1_full", sf[0], 1'b1);
    rdy[0] = 1'b1; iss[0] = 1'b1;
    tick();
    chk("tp1_ops", got_ops(0), 48'hABCD_1234);
    chk("tp1_sf_clear", sf[0], 1'b0);
    tick();
    chk("tp1_drained", got_qc(0), 2'd0);
    rdy[0] = 1'b0;

    // queue full on the sticky instance
    load(1, 2'd0, 16'h0001);
    load(1, 2'd1, 16'h0002);
    for (int n = 0; n < 3; n++) begin
      iss[1] = 1'b1;
      tick();
    end
    chk("full_cnt", got_qc(1), 2'd2);
    chk("full_err", ie[1], 1'b1);
    rdy[1] = 1'b1; iss[1] = 1'b1;
    tick();
    chk("full_reuse_cnt", got_qc(1), 2'd2);
    chk("full_reuse_err", ie[1], 1'b0);
    chk("full_head", got_ops(1), 48'h0002_0001);
    tick();
    tick();
    rdy[1] = 1'b0;

    // incomplete issue
    load(2, 2'd0, 16'h5555);
    iss[2] = 1'b1;
    tick();
    chk("inc_err", ie[2], 1'b1);
    chk("inc_cnt", got_qc(2), 2'd0);
    tick();
    chk("inc_err_pulse", ie[2], 1'b0);

    // load/issue collision
    load(0, 2'd0, 16'h0011);
    load(0, 2'd1, 16'h0022);
    iss[0] = 1'b1; ld[0] = 1'b1; sel[0] = 2'd0; dat[0] = 16'h0099;
    tick();
    chk("col_ops", got_ops(0), 48'h0022_0011);
    chk("col_sf", sf[0], 1'b0);
    load(0, 2'd1, 16'h0033);
    iss[0] = 1'b1;
    tick();
    rdy[0] = 1'b1;
    tick();
    chk("col_next", got_ops(0), 48'h0033_0099);
    tick();
    rdy[0] = 1'b0;

    // out-of-range select, then pointer wrap on the depth-3 queue
    load(2, 2'd3, 16'hDEAD);
    chk("oor_sf", sf[2], 1'b0);
    rdy[2] = 1'b1;
    for (int r = 0; r < 5; r++) begin
      load(2, 2'd0, 16'(16'h100 + r));
      load(2, 2'd1, 16'(16'h200 + r));
      load(2, 2'd2, 16'(16'h300 + r));
      iss[2] = 1'b1;
      tick();
      chk("wrap_head", got_ops(2), {16'(16'h300 + r), 16'(16'h200 + r), 16'(16'h100 + r)});
    end
    tick();
    rdy[2] = 1'b0;

    // random traffic on all instances
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 3; k++) begin
        ld[k]  = ($urandom_range(0, 9) < 6);
        sel[k] = (k == 2) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 1));
        dat[k] = 16'($urandom);
        iss[k] = ($urandom_range(0, 9) < 4);
        rdy[k] = ($urandom_range(0, 9) < 5);
      end
      tick();
    end

    // synchronous-looking reset, then async reset with two bundles queued
    ld = '0; iss = '0; rdy = '0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    load(1, 2'd0, 16'h0007);
    load(1, 2'd1, 16'h0008);
    iss[1] = 1'b1;
    tick();
    iss[1] = 1'b1;
    tick();
    chk("ar_pre_cnt", got_qc(1), 2'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", av[1], 1'b0);
    chk("ar_cnt", got_qc(1), 2'd0);
    chk("ar_ops", got_ops(1), 48'h0);
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
